// File: rtl/easyaxi_rd_slice.sv
// easyaxi_rd_slice: AR/R register slice between EASYAXI master and slave.
// Each channel is an independent 2-entry skid buffer, or a plain wire when
// its *_REG parameter is 0.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

// Generic valid/ready skid buffer. in_ready and out_valid come straight
// from flops, so no combinational path crosses the slice.
module easyaxi_rd_slice_skid #(
  parameter int unsigned W   = 8,
  parameter bit          REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);
  generate
    if (REG) begin : g_reg
      // bit0 = main entry valid, bit1 = skid entry valid
      typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
      } state_t;

      state_t       r_state;
      state_t       w_state_nxt;
      logic [W-1:0] r_main_data;
      logic [W-1:0] r_skid_data;
      logic         w_acc_in;
      logic         w_acc_out;
      logic         w_load_main;
      logic         w_main_from_skid;
      logic         w_load_skid;

      assign o_in_ready  = (r_state != FULL);
      assign o_out_valid = (r_state != EMPTY);
      assign o_out_data  = r_main_data;
      assign w_acc_in    = i_in_valid & o_in_ready;
      assign w_acc_out   = o_out_valid & i_out_ready;

      // Next-state and payload-steering decode
      always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
          EMPTY: begin
            if (w_acc_in) begin
              w_load_main = 1'b1;
              w_state_nxt = ONE;
            end
          end
          ONE: begin
            if (w_acc_in && w_acc_out) begin
              w_load_main = 1'b1;
            end else if (w_acc_in) begin
              w_load_skid = 1'b1;
              w_state_nxt = FULL;
            end else if (w_acc_out) begin
              w_state_nxt = EMPTY;
            end
          end
          FULL: begin
            if (w_acc_out) begin
              w_main_from_skid = 1'b1;
              w_state_nxt      = ONE;
            end
          end
          default: w_state_nxt = EMPTY;
        endcase
      end

      // State register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= EMPTY;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      // Payload registers, loaded only on acceptance or skid drain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end else begin
          if (w_load_main) begin
            r_main_data <= i_in_data;
          end else if (w_main_from_skid) begin
            r_main_data <= r_skid_data;
          end
          if (w_load_skid) begin
            r_skid_data <= i_in_data;
          end
        end
      end
    end else begin : g_pass
      logic w_unused_ok;
      assign w_unused_ok = clk ^ rst_n;
      assign o_out_valid = i_in_valid;
      assign o_out_data  = i_in_data;
      assign o_in_ready  = i_out_ready;
    end
  endgenerate
endmodule

module easyaxi_rd_slice #(
  parameter bit AR_REG = 1'b1,
  parameter bit R_REG  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_arvalid,
  output logic                    axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
  output logic                    axi_slv_rvalid,
  input  logic                    axi_slv_rready,
  output logic [`AXI_ID_W-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                    axi_slv_rlast,
  output logic                    axi_mst_arvalid,
  input  logic                    axi_mst_arready,
  output logic [`AXI_ID_W-1:0]    axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]  axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]   axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]  axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0] axi_mst_arburst,
  input  logic                    axi_mst_rvalid,
  output logic                    axi_mst_rready,
  input  logic [`AXI_ID_W-1:0]    axi_mst_rid,
  input  logic [`AXI_DATA_W-1:0]  axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]  axi_mst_rresp,
  input  logic                    axi_mst_rlast
);
  localparam int unsigned AR_W = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W
                               + `AXI_SIZE_W + `AXI_BURST_W;
  localparam int unsigned R_W  = `AXI_ID_W + `AXI_DATA_W + `AXI_RESP_W + 1;

  logic [AR_W-1:0] w_ar_in;
  logic [AR_W-1:0] w_ar_out;
  logic [R_W-1:0]  w_r_in;
  logic [R_W-1:0]  w_r_out;

  assign w_ar_in = {axi_slv_arid, axi_slv_araddr, axi_slv_arlen,
                    axi_slv_arsize, axi_slv_arburst};
  assign {axi_mst_arid, axi_mst_araddr, axi_mst_arlen,
          axi_mst_arsize, axi_mst_arburst} = w_ar_out;

  assign w_r_in = {axi_mst_rid, axi_mst_rdata, axi_mst_rresp, axi_mst_rlast};
  assign {axi_slv_rid, axi_slv_rdata, axi_slv_rresp, axi_slv_rlast} = w_r_out;

  easyaxi_rd_slice_skid #(
    .W   (AR_W),
    .REG (AR_REG)
  ) u_ar (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (axi_slv_arvalid),
    .o_in_ready  (axi_slv_arready),
    .i_in_data   (w_ar_in),
    .o_out_valid (axi_mst_arvalid),
    .i_out_ready (axi_mst_arready),
    .o_out_data  (w_ar_out)
  );

  easyaxi_rd_slice_skid #(
    .W   (R_W),
    .REG (R_REG)
  ) u_r (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (axi_mst_rvalid),
    .o_in_ready  (axi_mst_rready),
    .i_in_data   (w_r_in),
    .o_out_valid (axi_slv_rvalid),
    .i_out_ready (axi_slv_rready),
    .o_out_data  (w_r_out)
  );
endmodule

// File: tb/tb_easyaxi_rd_slice.sv
// Directed and randomized checks of easyaxi_rd_slice in registered and
// pass-through configurations. Both instances share stimulus; pt selects
// which one the checks observe.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_slice;
  localparam int IDW = `AXI_ID_W;
  localparam int AW  = `AXI_ADDR_W;
  localparam int LW  = `AXI_LEN_W;
  localparam int SW  = `AXI_SIZE_W;
  localparam int BW  = `AXI_BURST_W;
  localparam int DW  = `AXI_DATA_W;
  localparam int RSW = `AXI_RESP_W;
  localparam int ARW = IDW + AW + LW + SW + BW;
  localparam int RW  = IDW + DW + RSW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit pt = 1'b0;
  int total = 0;
  int bad = 0;

  // shared stimulus
  logic           s_arvalid;
  logic [ARW-1:0] s_ar_pl;
  logic           m_arready;
  logic           m_rvalid;
  logic [RW-1:0]  m_r_pl;
  logic           s_rready;

  // registered instance outputs
  wire            g_s_arready, g_m_arvalid, g_s_rvalid, g_m_rready;
  wire [ARW-1:0]  g_m_ar_pl;
  wire [RW-1:0]   g_s_r_pl;
  // pass-through instance outputs
  wire            p_s_arready, p_m_arvalid, p_s_rvalid, p_m_rready;
  wire [ARW-1:0]  p_m_ar_pl;
  wire [RW-1:0]   p_s_r_pl;

  // observed outputs of the selected instance
  logic           s_arready, m_arvalid, s_rvalid, m_rready;
  logic [ARW-1:0] m_ar_pl;
  logic [RW-1:0]  s_r_pl;
  assign s_arready = pt ? p_s_arready : g_s_arready;
  assign m_arvalid = pt ? p_m_arvalid : g_m_arvalid;
  assign s_rvalid  = pt ? p_s_rvalid  : g_s_rvalid;
  assign m_rready  = pt ? p_m_rready  : g_m_rready;
  assign m_ar_pl   = pt ? p_m_ar_pl   : g_m_ar_pl;
  assign s_r_pl    = pt ? p_s_r_pl    : g_s_r_pl;

  easyaxi_rd_slice #(.AR_REG(1'b1), .R_REG(1'b1)) dut_reg (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (s_arvalid),
    .axi_slv_arready (g_s_arready),
    .axi_slv_arid    (s_ar_pl[ARW-1 -: IDW]),
    .axi_slv_araddr  (s_ar_pl[AW+LW+SW+BW-1 -: AW]),
    .axi_slv_arlen   (s_ar_pl[LW+SW+BW-1 -: LW]),
    .axi_slv_arsize  (s_ar_pl[SW+BW-1 -: SW]),
    .axi_slv_arburst (s_ar_pl[BW-1:0]),
    .axi_slv_rvalid  (g_s_rvalid),
    .axi_slv_rready  (s_rready),
    .axi_slv_rid     (g_s_r_pl[RW-1 -: IDW]),
    .axi_slv_rdata   (g_s_r_pl[DW+RSW -: DW]),
    .axi_slv_rresp   (g_s_r_pl[RSW:1]),
    .axi_slv_rlast   (g_s_r_pl[0]),
    .axi_mst_arvalid (g_m_arvalid),
    .axi_mst_arready (m_arready),
    .axi_mst_arid    (g_m_ar_pl[ARW-1 -: IDW]),
    .axi_mst_araddr  (g_m_ar_pl[AW+LW+SW+BW-1 -: AW]),
    .axi_mst_arlen   (g_m_ar_pl[LW+SW+BW-1 -: LW]),
    .axi_mst_arsize  (g_m_ar_pl[SW+BW-1 -: SW]),
    .axi_mst_arburst (g_m_ar_pl[BW-1:0]),
    .axi_mst_rvalid  (m_rvalid),
    .axi_mst_rready  (g_m_rready),
    .axi_mst_rid     (m_r_pl[RW-1 -: IDW]),
    .axi_mst_rdata   (m_r_pl[DW+RSW -: DW]),
    .axi_mst_rresp   (m_r_pl[RSW:1]),
    .axi_mst_rlast   (m_r_pl[0])
  );

  easyaxi_rd_slice #(.AR_REG(1'b0), .R_REG(1'b0)) dut_pt (
    .clk             (clk),
    .rst_n           (rst_n),
    .axi_slv_arvalid (s_arvalid),
    .axi_slv_arready (p_s_arready),
    .axi_slv_arid    (s_ar_pl[ARW-1 -: IDW]),
    .axi_slv_araddr  (s_ar_pl[AW+LW+SW+BW-1 -: AW]),
    .axi_slv_arlen   (s_ar_pl[LW+SW+BW-1 -: LW]),
    .axi_slv_arsize  (s_ar_pl[SW+BW-1 -: SW]),
    .axi_slv_arburst (s_ar_pl[BW-1:0]),
    .axi_slv_rvalid  (p_s_rvalid),
    .axi_slv_rready  (s_rready),
    .axi_slv_rid     (p_s_r_pl[RW-1 -: IDW]),
    .axi_slv_rdata   (p_s_r_pl[DW+RSW -: DW]),
    .axi_slv_rresp   (p_s_r_pl[RSW:1]),
    .axi_slv_rlast   (p_s_r_pl[0]),
    .axi_mst_arvalid (p_m_arvalid),
    .axi_mst_arready (m_arready),
    .axi_mst_arid    (p_m_ar_pl[ARW-1 -: IDW]),
    .axi_mst_araddr  (p_m_ar_pl[AW+LW+SW+BW-1 -: AW]),
    .axi_mst_arlen   (p_m_ar_pl[LW+SW+BW-1 -: LW]),
    .axi_mst_arsize  (p_m_ar_pl[SW+BW-1 -: SW]),
    .axi_mst_arburst (p_m_ar_pl[BW-1:0]),
    .axi_mst_rvalid  (m_rvalid),
    .axi_mst_rready  (p_m_rready),
    .axi_mst_rid     (m_r_pl[RW-1 -: IDW]),
    .axi_mst_rdata   (m_r_pl[DW+RSW -: DW]),
    .axi_mst_rresp   (m_r_pl[RSW:1]),
    .axi_mst_rlast   (m_r_pl[0])
  );

  task automatic test_reset();
    pt = 1'b0;
    rst_n = 1'b0;
    s_arvalid = 1'b0; s_ar_pl = '0; m_arready = 1'b0;
    m_rvalid = 1'b0;  m_r_pl = '0;  s_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", m_arvalid); end
    total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", s_rvalid); end
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL reset_arready got=%b exp=1", s_arready); end
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL reset_rready got=%b exp=1", m_rready); end
    total++; if (m_ar_pl !== '0) begin bad++; $display("FAIL reset_ar_payload got=%h exp=0", m_ar_pl); end
    total++; if (s_r_pl !== '0) begin bad++; $display("FAIL reset_r_payload got=%h exp=0", s_r_pl); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_ar();
    logic [ARW-1:0] exp;
    exp = {IDW'(3), AW'(32'h100), LW'(0), SW'(2), BW'(1)};
    m_arready = 1'b1; s_rready = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b1; s_ar_pl = exp;
    @(negedge clk);
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL single_arready got=%b exp=1", s_arready); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", m_arvalid); end
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_ar_pl = '0;
    @(negedge clk);
    total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", m_arvalid); end
    total++; if (m_ar_pl !== exp) begin bad++; $display("FAIL single_payload got=%h exp=%h", m_ar_pl, exp); end
    @(negedge clk);
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b exp=0", m_arvalid); end
  endtask

  task automatic test_ar_backpressure();
    int idx = 0;
    int rcv = 0;
    logic [ARW-1:0] exp;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      m_arready = (c >= 5);
      if (idx < 8) begin
        s_arvalid = 1'b1;
        s_ar_pl = {IDW'(idx), AW'(idx * 4), LW'(0), SW'(2), BW'(1)};
      end else begin
        s_arvalid = 1'b0;
      end
      @(negedge clk);
      total++; if (s_arready !== ((c < 2) || (c >= 6))) begin
        bad++; $display("FAIL bp_arready cyc=%0d got=%b exp=%b", c, s_arready, ((c < 2) || (c >= 6)));
      end
      total++; if (m_arvalid !== ((c >= 1) && (c <= 12))) begin
        bad++; $display("FAIL bp_arvalid cyc=%0d got=%b exp=%b", c, m_arvalid, ((c >= 1) && (c <= 12)));
      end
      if (m_arvalid && m_arready) begin
        exp = {IDW'(rcv), AW'(rcv * 4), LW'(0), SW'(2), BW'(1)};
        total++; if (m_ar_pl !== exp) begin bad++; $display("FAIL bp_order beat=%0d got=%h exp=%h", rcv, m_ar_pl, exp); end
        rcv++;
      end
      if (s_arvalid && s_arready) idx++;
    end
    total++; if (rcv != 8) begin bad++; $display("FAIL bp_count got=%0d exp=8", rcv); end
    s_arvalid = 1'b0;
  endtask

  task automatic test_r_burst();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int sent = 0;
    int rcv = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [RW-1:0] ppl = '0;
    logic [RW-1:0] exp;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      s_rready = (c < 7) ? pat[c] : 1'b1;
      if (sent < 4) begin
        m_rvalid = 1'b1;
        m_r_pl = {IDW'(5), DW'(32'hA0 + sent), RSW'(0), (sent == 3)};
      end else begin
        m_rvalid = 1'b0;
      end
      @(negedge clk);
      if (pv && !pr) begin
        total++; if ({s_rvalid, s_r_pl} !== {1'b1, ppl}) begin
          bad++; $display("FAIL rb_stall cyc=%0d got=%b/%h exp=1/%h", c, s_rvalid, s_r_pl, ppl);
        end
      end
      if (s_rvalid && s_rready) begin
        exp = {IDW'(5), DW'(32'hA0 + rcv), RSW'(0), (rcv == 3)};
        total++; if (s_r_pl !== exp) begin bad++; $display("FAIL rb_beat beat=%0d got=%h exp=%h", rcv, s_r_pl, exp); end
        if (rcv == 3) begin
          total++; if (c != 7) begin bad++; $display("FAIL rb_last_cycle got=%0d exp=7", c); end
        end
        rcv++;
      end
      if (m_rvalid && m_rready) sent++;
      pv = s_rvalid; pr = s_rready; ppl = s_r_pl;
    end
    total++; if (rcv != 4) begin bad++; $display("FAIL rb_count got=%0d exp=4", rcv); end
  endtask

  task automatic test_random(input int n);
    int ar_sent = 0, ar_rcv = 0, r_sent = 0, r_rcv = 0, cyc = 0;
    logic [ARW-1:0] arq [$];
    logic [RW-1:0]  rq [$];
    logic ar_pv = 1'b0, ar_pr = 1'b0, r_pv = 1'b0, r_pr = 1'b0;
    logic ar_acc = 1'b0, r_acc = 1'b0;
    logic [ARW-1:0] ar_ppl = '0, ar_exp;
    logic [RW-1:0]  r_ppl = '0, r_exp;
    s_arvalid = 1'b0; m_rvalid = 1'b0;
    while ((ar_rcv < n || r_rcv < n) && cyc < n * 8 + 200) begin
      @(posedge clk); #1;
      if (ar_acc) s_arvalid = 1'b0;
      if (r_acc) m_rvalid = 1'b0;
      if (!s_arvalid && ar_sent < n && $urandom_range(0, 99) < 70) begin
        s_arvalid = 1'b1; s_ar_pl = ARW'({$urandom, $urandom});
      end
      if (!m_rvalid && r_sent < n && $urandom_range(0, 99) < 70) begin
        m_rvalid = 1'b1; m_r_pl = RW'({$urandom, $urandom});
      end
      m_arready = ($urandom_range(0, 99) < 60);
      s_rready  = ($urandom_range(0, 99) < 60);
      @(negedge clk);
      if (ar_pv && !ar_pr) begin
        total++; if ({m_arvalid, m_ar_pl} !== {1'b1, ar_ppl}) begin
          bad++; $display("FAIL rnd_ar_stable cyc=%0d got=%b/%h exp=1/%h", cyc, m_arvalid, m_ar_pl, ar_ppl);
        end
      end
      if (r_pv && !r_pr) begin
        total++; if ({s_rvalid, s_r_pl} !== {1'b1, r_ppl}) begin
          bad++; $display("FAIL rnd_r_stable cyc=%0d got=%b/%h exp=1/%h", cyc, s_rvalid, s_r_pl, r_ppl);
        end
      end
      ar_acc = s_arvalid && s_arready;
      r_acc  = m_rvalid && m_rready;
      if (ar_acc) begin arq.push_back(s_ar_pl); ar_sent++; end
      if (r_acc) begin rq.push_back(m_r_pl); r_sent++; end
      if (m_arvalid && m_arready) begin
        ar_exp = (arq.size() > 0) ? arq.pop_front() : 'x;
        total++; if (m_ar_pl !== ar_exp) begin bad++; $display("FAIL rnd_ar_beat n=%0d got=%h exp=%h", ar_rcv, m_ar_pl, ar_exp); end
        ar_rcv++;
      end
      if (s_rvalid && s_rready) begin
        r_exp = (rq.size() > 0) ? rq.pop_front() : 'x;
        total++; if (s_r_pl !== r_exp) begin bad++; $display("FAIL rnd_r_beat n=%0d got=%h exp=%h", r_rcv, s_r_pl, r_exp); end
        r_rcv++;
      end
      ar_pv = m_arvalid; ar_pr = m_arready; ar_ppl = m_ar_pl;
      r_pv = s_rvalid; r_pr = s_rready; r_ppl = s_r_pl;
      cyc++;
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0; m_rvalid = 1'b0;
    total++; if (ar_rcv != n) begin bad++; $display("FAIL rnd_ar_count got=%0d exp=%0d", ar_rcv, n); end
    total++; if (r_rcv != n) begin bad++; $display("FAIL rnd_r_count got=%0d exp=%0d", r_rcv, n); end
    total++; if (arq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL rnd_leftover got=%0d/%0d exp=0/0", arq.size(), rq.size());
    end
  endtask

  task automatic test_reset_full();
    int sent = 0;
    int rcv = 0;
    logic [RW-1:0] exp;
    pt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      s_arvalid = 1'b0; m_arready = 1'b1; s_rready = 1'b0;
      m_rvalid = 1'b1; m_r_pl = {IDW'(1), DW'(32'hDEAD0 + c), RSW'(0), 1'b0};
    end
    @(negedge clk);
    total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL rf_full_rready got=%b exp=0", m_rready); end
    total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL rf_full_rvalid got=%b exp=1", s_rvalid); end
    #2;
    rst_n = 1'b0; m_rvalid = 1'b0;
    #1;
    total++; if (s_rvalid !== 1'b0) begin bad++; $display("FAIL rf_rst_rvalid got=%b exp=0", s_rvalid); end
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL rf_rst_rready got=%b exp=1", m_rready); end
    total++; if (s_r_pl !== '0) begin bad++; $display("FAIL rf_rst_payload got=%h exp=0", s_r_pl); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      s_rready = 1'b1;
      if (sent < 2) begin
        m_rvalid = 1'b1; m_r_pl = {IDW'(2), DW'(32'hB0 + sent), RSW'(0), (sent == 1)};
      end else begin
        m_rvalid = 1'b0;
      end
      @(negedge clk);
      if (s_rvalid && s_rready) begin
        exp = {IDW'(2), DW'(32'hB0 + rcv), RSW'(0), (rcv == 1)};
        total++; if (s_r_pl !== exp) begin bad++; $display("FAIL rf_post_beat beat=%0d got=%h exp=%h", rcv, s_r_pl, exp); end
        rcv++;
      end
      if (m_rvalid && m_rready) sent++;
    end
    total++; if (rcv != 2) begin bad++; $display("FAIL rf_post_count got=%0d exp=2", rcv); end
  endtask

  task automatic test_passthrough();
    logic [ARW-1:0] ar_exp;
    logic [RW-1:0]  r_exp;
    ar_exp = {IDW'(7), AW'(32'h2000), LW'(3), SW'(2), BW'(1)};
    r_exp  = {IDW'(2), DW'(32'h12345678), RSW'(2), 1'b1};
    pt = 1'b1;
    @(posedge clk); #1;
    s_arvalid = 1'b1; s_ar_pl = ar_exp; m_arready = 1'b0;
    m_rvalid = 1'b1;  m_r_pl = r_exp;   s_rready = 1'b0;
    #1;
    total++; if (m_arvalid !== 1'b1) begin bad++; $display("FAIL pt_arvalid got=%b exp=1", m_arvalid); end
    total++; if (m_ar_pl !== ar_exp) begin bad++; $display("FAIL pt_ar_payload got=%h exp=%h", m_ar_pl, ar_exp); end
    total++; if (s_arready !== 1'b0) begin bad++; $display("FAIL pt_arready_lo got=%b exp=0", s_arready); end
    total++; if (s_rvalid !== 1'b1) begin bad++; $display("FAIL pt_rvalid got=%b exp=1", s_rvalid); end
    total++; if (s_r_pl !== r_exp) begin bad++; $display("FAIL pt_r_payload got=%h exp=%h", s_r_pl, r_exp); end
    total++; if (m_rready !== 1'b0) begin bad++; $display("FAIL pt_rready_lo got=%b exp=0", m_rready); end
    #1;
    m_arready = 1'b1; s_rready = 1'b1;
    #1;
    total++; if (s_arready !== 1'b1) begin bad++; $display("FAIL pt_arready_hi got=%b exp=1", s_arready); end
    total++; if (m_rready !== 1'b1) begin bad++; $display("FAIL pt_rready_hi got=%b exp=1", m_rready); end
    @(posedge clk); #1;
    s_arvalid = 1'b0; m_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_ar();
    test_ar_backpressure();
    test_r_burst();
    test_random(10000);
    test_reset_full();
    test_passthrough();
    test_random(1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
